// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
// Data port has priority; a starvation guard forces a waiting fetch through.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [2:0]  IF_DMTYPE      = 3'b000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [2:0]  dm_type,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  mem_type,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [1:0]  grant,
  output logic        err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  // Encodings double as the grant output value.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GNT_IF = 2'b01,
    GNT_DM = 2'b10
  } state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   starve_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            dm_win;
  logic            tmo_hit;
  logic            done;

  always_comb begin
    state_nxt = state;
    dm_win    = dm_req && !(if_req && (starve_cnt == STARVE_MAX));
    tmo_hit   = (state != IDLE) && !mem_ack && (tmo_cnt == TMO_LAST);
    done      = (state != IDLE) && (mem_ack || tmo_hit);
    if_ready  = 1'b0;
    if_rdata  = '0;
    dm_ready  = 1'b0;
    dm_rdata  = '0;

    case (state)
      IDLE: begin
        if (dm_win)      state_nxt = GNT_DM;
        else if (if_req) state_nxt = GNT_IF;
      end
      GNT_IF: begin
        if_ready = done;
        if (mem_ack) if_rdata = mem_rdata;
        if (done) state_nxt = IDLE;
      end
      GNT_DM: begin
        dm_ready = done;
        if (mem_ack) dm_rdata = mem_rdata;
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_req = (state != IDLE);
  assign grant   = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      err        <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_type   <= '0;
      mem_wdata  <= '0;
    end else begin
      state <= state_nxt;
      if (tmo_hit) err <= 1'b1;
      if (state == IDLE) begin
        tmo_cnt <= '0;
        if (dm_win) begin
          mem_addr  <= dm_addr;
          mem_we    <= dm_we;
          mem_type  <= dm_type;
          mem_wdata <= dm_wdata;
          // Count only grants that actually made a fetch wait.
          if (!if_req)                       starve_cnt <= '0;
          else if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
        end else if (if_req) begin
          mem_addr   <= if_addr;
          mem_we     <= 1'b0;
          mem_type   <= IF_DMTYPE;
          mem_wdata  <= '0;
          starve_cnt <= '0;
        end
      end else if (!mem_ack) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected completions into a
// scoreboard queue; a monitor pops and compares on every ready pulse.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we, mem_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [2:0]  dm_type;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ready, dm_ready, mem_req, mem_we, err;
  logic [2:0]  mem_type;
  logic [1:0]  grant;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_type(dm_type), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_type(mem_type), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .grant(grant), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_dm;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [2:0]  typ;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_cnt = 0;
  int   ack_delay = 0;
  bit   ack_en = 1'b1;
  bit   force_ack = 1'b0;
  int   last_if_cyc, last_dm_cyc;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void push_if(input logic [31:0] addr, input logic [31:0] rdata);
    exp_t e;
    e.is_dm = 1'b0; e.addr = addr; e.we = 1'b0; e.wdata = '0; e.typ = 3'b000; e.rdata = rdata;
    sb.push_back(e);
  endfunction

  function automatic void push_dm(input logic [31:0] addr, input logic we,
                                  input logic [31:0] wdata, input logic [31:0] rdata);
    exp_t e;
    e.is_dm = 1'b1; e.addr = addr; e.we = we; e.wdata = wdata; e.typ = 3'b010; e.rdata = rdata;
    sb.push_back(e);
  endfunction

  // Memory model: read data is address + 3; acks after ack_delay grant cycles.
  initial begin
    int wc;
    wc = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      if (force_ack) begin
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
      end else if (mem_req && ack_en) begin
        if (wc >= ack_delay) begin
          mem_ack = 1'b1; mem_rdata = mem_addr + 32'd3; wc = 0;
        end else begin
          mem_ack = 1'b0; mem_rdata = '0; wc++;
        end
      end else begin
        mem_ack = 1'b0; mem_rdata = '0; wc = 0;
      end
    end
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_ready || dm_ready) begin
        chk("single_ready", {31'b0, if_ready & dm_ready}, 32'd0);
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ready: if_ready=%b dm_ready=%b expected none", if_ready, dm_ready);
        end else begin
          e = sb.pop_front();
          chk("ready_port", {31'b0, dm_ready}, {31'b0, e.is_dm});
          chk("rdata", e.is_dm ? dm_rdata : if_rdata, e.rdata);
          chk("other_rdata_zero", e.is_dm ? if_rdata : dm_rdata, 32'd0);
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_we", {31'b0, mem_we}, {31'b0, e.we});
          chk("mem_wdata", mem_wdata, e.wdata);
          chk("mem_type", {29'b0, mem_type}, {29'b0, e.typ});
          chk("grant", {30'b0, grant}, e.is_dm ? 32'd2 : 32'd1);
          chk("mem_req", {31'b0, mem_req}, 32'd1);
        end
      end
    end
  end

  // Both requesters hold req until ready, then present the next address or drop.
  task automatic run_traffic(input int n_if, input int n_dm, input logic [31:0] if_base,
                             input logic [31:0] dm_base, input logic [31:0] dm_wbase);
    int  ic, dc, cyc;
    bit  got_if, got_dm;
    ic = 0; dc = 0; cyc = 0;
    if_addr  = if_base;
    dm_addr  = dm_base;
    dm_wdata = dm_wbase;
    dm_we    = 1'b1;
    dm_type  = 3'b010;
    if_req   = (n_if > 0);
    dm_req   = (n_dm > 0);
    while ((ic < n_if || dc < n_dm) && cyc < 200) begin
      @(negedge clk);
      got_if = if_ready;
      got_dm = dm_ready;
      if (got_if) last_if_cyc = cyc_cnt;
      if (got_dm) last_dm_cyc = cyc_cnt;
      @(posedge clk); #1;
      if (got_if) begin
        ic++;
        if_addr = if_base + 32'(4 * ic);
        if_req  = (ic < n_if);
      end
      if (got_dm) begin
        dc++;
        dm_addr  = dm_base + 32'(4 * dc);
        dm_wdata = dm_wbase + 32'(dc);
        dm_we    = ~dm_we;
        dm_req   = (dc < n_dm);
      end
      cyc++;
    end
    chk("traffic_bounded", {31'b0, (ic < n_if || dc < n_dm)}, 32'd0);
    if_req = 1'b0;
    dm_req = 1'b0;
  endtask

  initial begin
    int  gcyc;
    bit  done;
    reset = 1'b1;
    if_req = 0; dm_req = 0; dm_we = 0; dm_type = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_grant", {30'b0, grant}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_type_we", {28'b0, mem_type, mem_we}, 32'd0);
    chk("rst_ready", {30'b0, if_ready, dm_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single fetch with zero-wait ack
    push_if(32'h10, 32'h13);
    run_traffic(1, 0, 32'h10, 32'h0, 32'h0);
    @(negedge clk);
    chk("t1_idle_grant", {30'b0, grant}, 32'd0);
    chk("t1_idle_mem_req", {31'b0, mem_req}, 32'd0);
    @(posedge clk); #1;

    // Simultaneous requests: DM store first, fetch two cycles later
    push_dm(32'h100, 1'b1, 32'hDEAD_BEEF, 32'h103);
    push_if(32'h20, 32'h23);
    run_traffic(1, 1, 32'h20, 32'h100, 32'hDEAD_BEEF);
    chk("t2_if_after_dm", 32'(last_if_cyc - last_dm_cyc), 32'd2);

    // Starvation guard: DM x4, IF, DM x2 (counter cleared), final IF
    for (int i = 0; i < 4; i++)
      push_dm(32'h200 + 32'(4 * i), ~i[0], 32'hC0DE_0000 + 32'(i), 32'h203 + 32'(4 * i));
    push_if(32'h1000, 32'h1003);
    push_dm(32'h210, 1'b1, 32'hC0DE_0004, 32'h213);
    push_dm(32'h214, 1'b0, 32'hC0DE_0005, 32'h217);
    push_if(32'h1004, 32'h1007);
    run_traffic(2, 6, 32'h1000, 32'h200, 32'hC0DE_0000);

    // Latched write data ignores mid-grant changes
    ack_delay = 2;
    push_dm(32'h300, 1'b1, 32'h1111_1111, 32'h303);
    dm_req = 1'b1; dm_we = 1'b1; dm_type = 3'b010;
    dm_addr = 32'h300; dm_wdata = 32'h1111_1111;
    @(posedge clk); #1;
    dm_wdata = 32'h2222_2222;
    dm_addr  = 32'h3F0;
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      chk("t4_hold_wdata", mem_wdata, 32'h1111_1111);
      if (dm_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    chk("t4_completed", {31'b0, done}, 32'd1);
    dm_req = 1'b0;
    ack_delay = 0;

    // Bus timeout on a fetch
    ack_en = 1'b0;
    push_if(32'h40, 32'h0);
    if_req = 1'b1; if_addr = 32'h40;
    gcyc = 0; done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (mem_req) gcyc++;
      if (if_ready) done = 1'b1;
    end
    chk("t5_timeout_seen", {31'b0, done}, 32'd1);
    chk("t5_timeout_cycles", 32'(gcyc), 32'd255);
    @(posedge clk); #1;
    if_req = 1'b0;
    ack_en = 1'b1;
    @(negedge clk);
    chk("t5_err_set", {31'b0, err}, 32'd1);
    @(posedge clk); #1;
    push_dm(32'h500, 1'b1, 32'h5555_0000, 32'h503);
    run_traffic(0, 1, 32'h0, 32'h500, 32'h5555_0000);
    @(negedge clk);
    chk("t5_err_sticky", {31'b0, err}, 32'd1);
    @(posedge clk); #1;

    // Reset in the second grant cycle, late ack afterwards
    ack_delay = 5;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h600;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("t6_in_grant", {30'b0, grant}, 32'd2);
    @(posedge clk); #1;
    reset = 1'b0;
    dm_req = 1'b0;
    force_ack = 1'b1;
    @(negedge clk);
    chk("t6_mem_req", {31'b0, mem_req}, 32'd0);
    chk("t6_grant", {30'b0, grant}, 32'd0);
    chk("t6_no_ready", {30'b0, if_ready, dm_ready}, 32'd0);
    chk("t6_err_cleared", {31'b0, err}, 32'd0);
    @(posedge clk); #1;
    force_ack = 1'b0;
    ack_delay = 0;
    @(negedge clk);
    chk("t6_still_idle", {30'b0, grant}, 32'd0);
    @(posedge clk); #1;

    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch port and data-memory port.
- Sits between the 5-stage cpu (inst/PC and Addr/Data/mem_w/DMType ports) and the memory model.
- Grants one requester at a time, with data-port priority and a starvation guard for fetch.
- Provides per-port ready handshakes that the top level turns into pipeline stalls, plus a bus-timeout error flag.

Parameters:
- STARVE_LIMIT, 4: consecutive contested DM grants before a pending IF request is forced through; must be ≥1.
- TIMEOUT_CYCLES, 255: cycles in a grant state without mem_ack before forced completion.
- IF_DMTYPE, 3'b000: DMType encoding driven on mem_type for fetches (32-bit word).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  32  fetch address (PC)
- if_rdata  out  32  fetched instruction, valid when if_ready=1
- if_ready  out  1  fetch completion, one cycle
- dm_req  in  1  data request, held until dm_ready
- dm_we  in  1  data write enable
- dm_type  in  3  DMType of data access
- dm_addr  in  32  data address
- dm_wdata  in  32  store data
- dm_rdata  out  32  load data, valid when dm_ready=1
- dm_ready  out  1  data completion, one cycle
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_type  out  3  memory access type
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, one cycle
- grant  out  2  current owner: 00 none, 01 IF, 10 DM
- err  out  1  sticky timeout flag

Behaviour:
- Reset values: mem_req/mem_we=0; mem_addr/mem_wdata=0; mem_type=0; grant=00; err=0; if_ready/dm_ready=0. Starve and timeout counters=0, FSM=IDLE.
- FSM states are IDLE, GNT_IF, GNT_DM.
- IDLE arbitration (at the clock edge):
  - dm_req & !(if_req & starve_cnt==STARVE_LIMIT) → GNT_DM.
  - Else if_req → GNT_IF.
  - Else stay in IDLE.
- On grant, latch into output registers:
  - IF grant: mem_addr←if_addr, mem_we←0, mem_type←IF_DMTYPE, mem_wdata←0.
  - DM grant: mem_addr←dm_addr, mem_we←dm_we, mem_type←dm_type, mem_wdata←dm_wdata.
  - Latched values hold for the whole grant; later requester input changes are ignored.
- mem_req=1 exactly while in a GNT state; grant mirrors the state.
- Completion (combinational) in GNT_x when mem_ack=1:
  - x_ready=1 and x_rdata=mem_rdata in that same cycle.
  - Next state is IDLE.
  - The requester drops or changes its req at the same edge.
- Non-owner ready is always 0; non-owner rdata=0.
- Latency: request sampled in IDLE at edge N → mem_req high in cycle N+1 → earliest ready in cycle N+1 (zero-wait ack). Minimum 2 cycles from request to next grant.
- Starve counter:
  - On a DM grant with if_req=1: increment, saturating at STARVE_LIMIT.
  - On an IF grant, or a DM grant with if_req=0: clear.
- Timeout counter:
  - Clears on entry to a GNT state and increments each GNT cycle without ack.
  - When it equals TIMEOUT_CYCLES-1 with no ack: x_ready=1, x_rdata=32'h0, err←1, next IDLE.
  - A simultaneous ack wins: normal data, no err.
- err clears only on reset.
- mem_ack in IDLE is ignored.
- Reset mid-grant: FSM goes to IDLE at the edge; mem_req=0 the next cycle; no ready pulse is produced; a late ack is ignored.
- Simultaneous dm_req and if_req with starve_cnt<STARVE_LIMIT: DM wins.

Test Plan:
- if_req=1, if_addr=0x0000_0010, memory acks in first grant cycle with 0x0000_0013 → grant=01, mem_addr=0x10 and if_ready=1 with if_rdata=0x13 in the same cycle; IDLE next cycle.
- if_req and dm_req (dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF) asserted together, 1-cycle ack → DM granted first (mem_we=1, mem_wdata=0xDEADBEEF), then IF granted two cycles later.
- dm_req held high for 6 transactions, if_req held high → grants DM,DM,DM,DM,IF,DM…; starve_cnt clears after the IF grant.
- dm_wdata changed from 0x1111_1111 to 0x2222_2222 mid-grant with 3-cycle ack delay → mem_wdata stays 0x1111_1111 until completion.
- No mem_ack in GNT_IF → if_ready=1 with if_rdata=0 on the 255th grant cycle; err=1 and stays 1; a subsequent normal transaction completes correctly.
- reset asserted in second cycle of GNT_DM, ack arrives one cycle later → mem_req=0, grant=00, dm_ready never pulses, err=0.
